// File: rtl/prefix_ctrl_decoder.sv
// Control decoder for the PREP-prefixed ISA: chained prefix windows, sticky halt,
// flush squash and a saturating illegal-op counter.
module prefix_ctrl_decoder #(
  parameter  int IMM_W    = 6,
  parameter  int MAX_PREP = 2,
  parameter  int CNT_W    = 8,
  localparam int PREP_W   = IMM_W * MAX_PREP,
  localparam int DEPTH_W  = $clog2(MAX_PREP + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [2:0]         opcode,
  input  logic [IMM_W-1:0]   imm,
  input  logic               flush,
  output logic               WritePrepReg,
  output logic               ReadPrepReg,
  output logic               WriteEnabled,
  output logic               DataWrite,
  output logic               DataRead,
  output logic [2:0]         ALUOp,
  output logic               controlBranch,
  output logic               aluRegSource,
  output logic               aluConstantOrOne,
  output logic               saveAluToReg,
  output logic               prepCommand,
  output logic [PREP_W-1:0]  prep_value,
  output logic [DEPTH_W-1:0] prep_depth,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   err_count
);

  typedef enum logic [1:0] {
    S_NORMAL,
    S_PREFIXED,
    S_HALTED
  } state_t;

  state_t             r_state;
  logic [PREP_W-1:0]  r_prep_value;
  logic [DEPTH_W-1:0] r_depth;
  logic [CNT_W-1:0]   r_err_count;

  logic               w_active;
  logic               w_room;
  logic               w_illegal;
  logic [PREP_W-1:0]  w_shifted;

  // A decoded instruction only exists when nothing squashes it this cycle.
  assign w_active  = instr_valid && !reset && !flush && (r_state != S_HALTED);
  assign w_room    = (r_depth < DEPTH_W'(MAX_PREP));
  assign w_shifted = PREP_W'({r_prep_value, imm});

  always_comb begin
    w_illegal = 1'b0;
    if (w_active) begin
      case (r_state)
        S_NORMAL:   w_illegal = (opcode == 3'b110);
        S_PREFIXED: w_illegal = (opcode[2:1] == 2'b11) || ((opcode == 3'b101) && !w_room);
        default:    w_illegal = 1'b0;
      endcase
    end
  end

  always_comb begin
    WritePrepReg     = 1'b0;
    ReadPrepReg      = 1'b0;
    WriteEnabled     = 1'b0;
    DataWrite        = 1'b0;
    DataRead         = 1'b0;
    ALUOp            = 3'b000;
    controlBranch    = 1'b0;
    aluRegSource     = 1'b0;
    aluConstantOrOne = 1'b0;
    saveAluToReg     = 1'b0;
    prepCommand      = 1'b0;
    if (w_active && !w_illegal) begin
      if (r_state == S_NORMAL) begin
        case (opcode)
          3'b000: begin
            WritePrepReg = 1'b1;
            WriteEnabled = 1'b1;
            prepCommand  = 1'b1;
          end
          3'b001: begin
            WriteEnabled     = 1'b1;
            aluConstantOrOne = 1'b1;
            saveAluToReg     = 1'b1;
            ALUOp            = imm[0] ? 3'b000 : 3'b001;
          end
          3'b010: begin
            WriteEnabled = 1'b1;
            aluRegSource = 1'b1;
            saveAluToReg = 1'b1;
            ALUOp        = 3'b010;
          end
          3'b011, 3'b100, 3'b101: begin
            WriteEnabled = 1'b1;
            saveAluToReg = 1'b1;
            ALUOp        = opcode;
          end
          default: ;
        endcase
      end else begin
        ReadPrepReg = 1'b1;
        case (opcode)
          3'b000: begin
            WriteEnabled = 1'b1;
            aluRegSource = 1'b1;
            saveAluToReg = 1'b1;
            ALUOp        = 3'b110;
          end
          3'b001: begin
            controlBranch = 1'b1;
            aluRegSource  = 1'b1;
            ALUOp         = 3'b010;
          end
          3'b010: begin
            WriteEnabled = 1'b1;
            DataRead     = 1'b1;
            aluRegSource = 1'b1;
          end
          3'b011: begin
            DataWrite    = 1'b1;
            aluRegSource = 1'b1;
          end
          3'b100: WriteEnabled = 1'b1;
          3'b101: begin
            WritePrepReg = 1'b1;
            WriteEnabled = 1'b1;
            saveAluToReg = 1'b1;
            ALUOp        = 3'b100;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_NORMAL;
      r_prep_value <= '0;
      r_depth      <= '0;
      r_err_count  <= '0;
    end else if (r_state != S_HALTED) begin
      if (flush) begin
        r_state      <= S_NORMAL;
        r_prep_value <= '0;
        r_depth      <= '0;
      end else if (instr_valid) begin
        if (w_illegal && (r_err_count != '1))
          r_err_count <= r_err_count + CNT_W'(1);
        case (r_state)
          S_NORMAL: begin
            if (opcode == 3'b000) begin
              r_state      <= S_PREFIXED;
              r_prep_value <= PREP_W'(imm);
              r_depth      <= DEPTH_W'(1);
            end else if (opcode == 3'b111) begin
              r_state <= S_HALTED;
            end
          end
          S_PREFIXED: begin
            // PSFT with room extends the window; every other op (legal or not) closes it.
            if ((opcode == 3'b101) && w_room) begin
              r_prep_value <= w_shifted;
              r_depth      <= r_depth + DEPTH_W'(1);
            end else begin
              r_state      <= S_NORMAL;
              r_prep_value <= '0;
              r_depth      <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign prep_value = r_prep_value;
  assign prep_depth = r_depth;
  assign halted     = (r_state == S_HALTED);
  assign illegal    = w_illegal;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_prefix_ctrl_decoder.sv
// Bench for prefix_ctrl_decoder: default instance plus a CNT_W=2 instance on the same
// stimulus, checked every cycle against a behavioural model and by directed literals.
module tb_prefix_ctrl_decoder;

  localparam int IMM_W    = 6;
  localparam int MAX_PREP = 2;
  localparam int PREP_W   = IMM_W * MAX_PREP;
  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [5:0] imm = 6'd0;
  logic       flush = 1'b0;

  logic a_wp, a_rp, a_we, a_dw, a_dr, a_br, a_rs, a_c1, a_sa, a_pc, a_halted, a_illegal;
  logic [2:0]  a_alu;
  logic [11:0] a_prep;
  logic [1:0]  a_depth;
  logic [7:0]  a_err;

  logic b_wp, b_rp, b_we, b_dw, b_dr, b_br, b_rs, b_c1, b_sa, b_pc, b_halted, b_illegal;
  logic [2:0]  b_alu;
  logic [11:0] b_prep;
  logic [1:0]  b_depth;
  logic [1:0]  b_err;

  logic [12:0] a_ctl, b_ctl;
  assign a_ctl = {a_wp, a_rp, a_we, a_dw, a_dr, a_alu, a_br, a_rs, a_c1, a_sa, a_pc};
  assign b_ctl = {b_wp, b_rp, b_we, b_dw, b_dr, b_alu, b_br, b_rs, b_c1, b_sa, b_pc};

  prefix_ctrl_decoder #(.IMM_W(IMM_W), .MAX_PREP(MAX_PREP), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode), .imm(imm),
    .flush(flush), .WritePrepReg(a_wp), .ReadPrepReg(a_rp), .WriteEnabled(a_we),
    .DataWrite(a_dw), .DataRead(a_dr), .ALUOp(a_alu), .controlBranch(a_br),
    .aluRegSource(a_rs), .aluConstantOrOne(a_c1), .saveAluToReg(a_sa),
    .prepCommand(a_pc), .prep_value(a_prep), .prep_depth(a_depth), .halted(a_halted),
    .illegal(a_illegal), .err_count(a_err)
  );

  prefix_ctrl_decoder #(.IMM_W(IMM_W), .MAX_PREP(MAX_PREP), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode), .imm(imm),
    .flush(flush), .WritePrepReg(b_wp), .ReadPrepReg(b_rp), .WriteEnabled(b_we),
    .DataWrite(b_dw), .DataRead(b_dr), .ALUOp(b_alu), .controlBranch(b_br),
    .aluRegSource(b_rs), .aluConstantOrOne(b_c1), .saveAluToReg(b_sa),
    .prepCommand(b_pc), .prep_value(b_prep), .prep_depth(b_depth), .halted(b_halted),
    .illegal(b_illegal), .err_count(b_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: window open flag, accumulated value, word count, halt, raw error count.
  bit m_win  = 1'b0;
  int m_val  = 0;
  int m_dep  = 0;
  bit m_halt = 1'b0;
  int m_err  = 0;

  function automatic logic [12:0] mk(bit wp, bit rp, bit we, bit dw, bit dr, logic [2:0] op,
                                     bit br, bit rs, bit c1, bit sa, bit pc);
    return {wp, rp, we, dw, dr, op, br, rs, c1, sa, pc};
  endfunction

  function automatic bit exp_ill();
    if (reset || !instr_valid || flush || m_halt) return 1'b0;
    if (!m_win) return opcode == 3'd6;
    return (opcode >= 3'd6) || (opcode == 3'd5 && m_dep >= MAX_PREP);
  endfunction

  function automatic logic [12:0] exp_ctl();
    if (reset || !instr_valid || flush || m_halt || exp_ill()) return '0;
    if (!m_win) begin
      case (opcode)
        3'd0: return mk(Y, N, Y, N, N, 3'd0, N, N, N, N, Y);
        3'd1: return mk(N, N, Y, N, N, imm[0] ? 3'd0 : 3'd1, N, N, Y, Y, N);
        3'd2: return mk(N, N, Y, N, N, 3'd2, N, Y, N, Y, N);
        3'd3: return mk(N, N, Y, N, N, 3'd3, N, N, N, Y, N);
        3'd4: return mk(N, N, Y, N, N, 3'd4, N, N, N, Y, N);
        3'd5: return mk(N, N, Y, N, N, 3'd5, N, N, N, Y, N);
        default: return '0;
      endcase
    end
    case (opcode)
      3'd0: return mk(N, Y, Y, N, N, 3'd6, N, Y, N, Y, N);
      3'd1: return mk(N, Y, N, N, N, 3'd2, Y, Y, N, N, N);
      3'd2: return mk(N, Y, Y, N, Y, 3'd0, N, Y, N, N, N);
      3'd3: return mk(N, Y, N, Y, N, 3'd0, N, Y, N, N, N);
      3'd4: return mk(N, Y, Y, N, N, 3'd0, N, N, N, N, N);
      3'd5: return mk(Y, Y, Y, N, N, 3'd4, N, N, N, Y, N);
      default: return '0;
    endcase
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    logic [12:0] ec;
    bit ei;
    if (reset) begin
      m_win = 1'b0; m_val = 0; m_dep = 0; m_halt = 1'b0; m_err = 0;
    end
    ec = exp_ctl();
    ei = exp_ill();
    chk("ctl", a_ctl, ec);
    chk("ctl_c2", b_ctl, ec);
    chk("illegal", a_illegal, ei);
    chk("illegal_c2", b_illegal, ei);
    chk("prep_value", a_prep, m_val);
    chk("prep_depth", a_depth, m_dep);
    chk("prep_c2", {b_depth, b_prep}, {m_dep[1:0], m_val[11:0]});
    chk("halted", a_halted, m_halt);
    chk("halted_c2", b_halted, m_halt);
    chk("err_count", a_err, sat(m_err, 255));
    chk("err_count_c2", b_err, sat(m_err, 3));
    if (!reset && !m_halt) begin
      if (flush) begin
        m_win = 1'b0; m_val = 0; m_dep = 0;
      end else if (instr_valid) begin
        if (ei) m_err++;
        if (!m_win) begin
          if (opcode == 3'd0) begin
            m_win = 1'b1; m_val = int'(imm); m_dep = 1;
          end else if (opcode == 3'd7) begin
            m_halt = 1'b1;
          end
        end else if (opcode == 3'd5 && m_dep < MAX_PREP) begin
          m_val = (m_val * (1 << IMM_W) + int'(imm)) % (1 << PREP_W);
          m_dep++;
        end else begin
          m_win = 1'b0; m_val = 0; m_dep = 0;
        end
      end
    end
  end

  task automatic step(input int v, input int op, input int im, input int fl);
    @(posedge clk);
    #1;
    instr_valid = v[0];
    opcode      = op[2:0];
    imm         = im[5:0];
    flush       = fl[0];
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset = 1'b0;

    step(1, 0, 'h2A, 0); #1 chk("prep_wp", a_wp, 1);
    step(1, 2, 0, 0);    #1
    chk("lw_prep_value", a_prep, 12'h02A);
    chk("lw_depth", a_depth, 1);
    chk("lw_rp", a_rp, 1);
    chk("lw_dr", a_dr, 1);
    step(0, 0, 0, 0);    #1
    chk("after_lw_depth", a_depth, 0);
    chk("after_lw_value", a_prep, 0);

    step(1, 0, 'h01, 0);
    step(1, 5, 'h3F, 0);
    step(1, 3, 0, 0);    #1
    chk("sw_prep_value", a_prep, 12'h07F);
    chk("sw_dw", a_dw, 1);

    step(1, 0, 'h01, 0);
    step(1, 5, 'h3F, 0);
    step(1, 5, 'h00, 0); #1
    chk("psft_over_illegal", a_illegal, 1);
    chk("psft_over_we", a_we, 0);
    step(0, 0, 0, 0);    #1
    chk("psft_over_err", a_err, 1);
    chk("psft_over_depth", a_depth, 0);

    step(1, 1, 'h01, 0); #1
    chk("inc_aluop", a_alu, 3'b000);
    chk("inc_one", a_c1, 1);
    step(1, 1, 'h00, 0); #1
    chk("dec_aluop", a_alu, 3'b001);
    chk("dec_one", a_c1, 1);

    step(1, 0, 'h05, 0);
    step(1, 1, 0, 1);    #1
    chk("flush_branch", a_br, 0);
    step(1, 2, 0, 0);    #1
    chk("flush_depth", a_depth, 0);
    chk("flush_value", a_prep, 0);
    chk("flush_xor_aluop", a_alu, 3'b010);
    chk("flush_xor_rp", a_rp, 0);

    step(1, 0, 'h15, 0);
    step(0, 4, 0, 0);    #1 chk("idle_rp", a_rp, 0);
    step(1, 4, 0, 0);    #1
    chk("hold_depth", a_depth, 1);
    chk("hold_value", a_prep, 12'h015);
    chk("save_we", a_we, 1);

    step(1, 0, 'h03, 0);
    step(1, 7, 0, 0);    #1 chk("pref_111_illegal", a_illegal, 1);
    step(1, 0, 'h03, 0);
    step(1, 6, 0, 0);    #1 chk("pref_110_illegal", a_illegal, 1);
    step(1, 2, 0, 0);    #1 chk("after_pref_illegal_halted", a_halted, 0);

    step(0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1, 6, i, 0); #1
      chk("sat_we", a_we, 0);
      if (i > 0) chk("sat_err_c2", b_err, sat_exp[i-1]);
    end
    step(0, 0, 0, 0);    #1
    chk("sat_err_c2_final", b_err, sat_exp[4]);
    chk("sat_err_8", a_err, 5);

    step(1, 7, 0, 0);
    step(1, 0, 'h2A, 0); #1
    chk("halt_flag", a_halted, 1);
    chk("halt_ctl", a_ctl, 0);
    step(1, 6, 0, 0);
    step(1, 0, 0, 1);    #1
    chk("halt_err_frozen", a_err, 5);
    chk("halt_survives_flush", a_halted, 1);
    #1 reset = 1'b1;
    #1 chk("async_reset_halted", a_halted, 0);
    step(0, 0, 0, 0);
    reset = 1'b0;
    step(1, 0, 'h2A, 0); #1 chk("post_reset_prep", a_wp, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
